pipe_idex_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage pipeline, directly downstream of pipeidcu.
- Captures decoded controls and operands from ID each cycle.
- Converts ID into a bubble on load-use stall or control flush.
- Feeds EX-stage status back to pipeidcu for hazard detection: ewreg, em2reg, ern, ex_is_uncond, ex_is_cond.
- Keeps saturating bubble and flush counters for performance debug.

---
 rtl/pipe_idex_reg.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_idex_reg.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_idex_reg.sv
// ----------------------------------------------------------------------------
// pipe_idex_reg
// ID/EX pipeline register of the 5-stage pipeline. Captures the decoded
// controls and operands from ID on every rising edge, turns the ID
// instruction into a bubble on a load-use stall or a control flush, exposes
// the EX-stage status that the ID hazard unit needs, and keeps two saturating
// event counters for performance debug.
//
// Ports
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   load_depen           load-use hazard from ID: insert a bubble into EX
//   flush                taken branch/jump resolved: cancel the ID instruction
//   d*                   ID-stage controls, register number and operands
//   e*                   registered EX-stage controls, register number, data
//   ex_is_uncond         EX holds j or jal
//   ex_is_cond           EX holds beq or bne
//   bubble_cnt           edges where a load_depen-only bubble was inserted
//   flush_cnt            edges where a flush bubble was inserted
// ----------------------------------------------------------------------------
module pipe_idex_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clock,
    input  logic          resetn,

    // hazard / flush requests
    input  logic          load_depen,
    input  logic          flush,

    // ID-stage controls
    input  logic          dwreg,
    input  logic          dm2reg,
    input  logic          dwmem,
    input  logic          djal,
    input  logic          dj,
    input  logic          dbeq,
    input  logic          dbne,
    input  logic [4:0]    daluc,
    input  logic          daluimm,
    input  logic          dshift,
    input  logic [1:0]    dstore_depen,
    input  logic [4:0]    drn,

    // ID-stage data
    input  logic [DW-1:0] da,
    input  logic [DW-1:0] db,
    input  logic [DW-1:0] dimm,
    input  logic [DW-1:0] dpc4,

    // EX-stage controls
    output logic          ewreg,
    output logic          em2reg,
    output logic          ewmem,
    output logic          ejal,
    output logic          ealuimm,
    output logic          eshift,
    output logic [4:0]    ealuc,
    output logic [1:0]    estore_depen,
    output logic [4:0]    ern,

    // EX-stage data
    output logic [DW-1:0] ea,
    output logic [DW-1:0] eb,
    output logic [DW-1:0] eimm,
    output logic [DW-1:0] epc4,

    // EX-stage status for the ID hazard unit
    output logic          ex_is_uncond,
    output logic          ex_is_cond,

    // performance-debug counters
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    logic          bub_c;
    logic          stall_only_c;

    logic          nxt_wreg_c;
    logic          nxt_m2reg_c;
    logic          nxt_wmem_c;
    logic          nxt_jal_c;
    logic          nxt_uncond_c;
    logic          nxt_cond_c;
    logic [1:0]    nxt_store_depen_c;
    logic [4:0]    nxt_rn_c;

    logic [CW-1:0] nxt_bubble_cnt_c;
    logic [CW-1:0] nxt_flush_cnt_c;

    // Bubble insertion: only the side-effecting controls are cleared; the
    // ALU selects and operands stay live since they cannot commit anything.
    always_comb begin
        bub_c             = flush | load_depen;
        // flush wins, so a simultaneous stall is attributed to the flush only
        stall_only_c      = load_depen & ~flush;

        nxt_wreg_c        = 1'b0;
        nxt_m2reg_c       = 1'b0;
        nxt_wmem_c        = 1'b0;
        nxt_jal_c         = 1'b0;
        nxt_uncond_c      = 1'b0;
        nxt_cond_c        = 1'b0;
        nxt_store_depen_c = 2'b00;
        nxt_rn_c          = 5'd0;

        if (!bub_c) begin
            nxt_wreg_c        = dwreg;
            nxt_m2reg_c       = dm2reg;
            nxt_wmem_c        = dwmem;
            nxt_jal_c         = djal;
            nxt_uncond_c      = dj | djal;
            nxt_cond_c        = dbeq | dbne;
            nxt_store_depen_c = dstore_depen;
            // drn is passed through even for $0; write masking lives downstream
            nxt_rn_c          = drn;
        end
    end

    // Saturating increments: hold at all-ones instead of wrapping.
    always_comb begin
        nxt_bubble_cnt_c = bubble_cnt;
        nxt_flush_cnt_c  = flush_cnt;

        if (stall_only_c && (bubble_cnt != CNT_MAX)) begin
            nxt_bubble_cnt_c = bubble_cnt + CNT_ONE;
        end

        if (flush && (flush_cnt != CNT_MAX)) begin
            nxt_flush_cnt_c = flush_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Control register (bubble-aware fields)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ewreg        <= 1'b0;
            em2reg       <= 1'b0;
            ewmem        <= 1'b0;
            ejal         <= 1'b0;
            ex_is_uncond <= 1'b0;
            ex_is_cond   <= 1'b0;
            estore_depen <= 2'b00;
            ern          <= 5'd0;
        end else begin
            ewreg        <= nxt_wreg_c;
            em2reg       <= nxt_m2reg_c;
            ewmem        <= nxt_wmem_c;
            ejal         <= nxt_jal_c;
            ex_is_uncond <= nxt_uncond_c;
            ex_is_cond   <= nxt_cond_c;
            estore_depen <= nxt_store_depen_c;
            ern          <= nxt_rn_c;
        end
    end

    // ------------------------------------------------------------------------
    // Operand-select and data register (loads unconditionally)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ealuc   <= 5'd0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            epc4    <= '0;
        end else begin
            ealuc   <= daluc;
            ealuimm <= daluimm;
            eshift  <= dshift;
            ea      <= da;
            eb      <= db;
            eimm    <= dimm;
            epc4    <= dpc4;
        end
    end

    // ------------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            bubble_cnt <= nxt_bubble_cnt_c;
            flush_cnt  <= nxt_flush_cnt_c;
        end
    end

endmodule

// File: tb/tb_pipe_idex_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_idex_reg
// Scoreboard bench for pipe_idex_reg (CW = 4 so saturation is reachable).
// The driver applies one ID vector per cycle and queues the EX image it
// should produce; the monitor pops and compares on each falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_idex_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          flush;
        logic          load_depen;
        logic          dwreg;
        logic          dm2reg;
        logic          dwmem;
        logic          djal;
        logic          dj;
        logic          dbeq;
        logic          dbne;
        logic [4:0]    daluc;
        logic          daluimm;
        logic          dshift;
        logic [1:0]    dstore_depen;
        logic [4:0]    drn;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [DW-1:0] dimm;
        logic [DW-1:0] dpc4;
    } in_t;

    typedef struct packed {
        logic          ewreg;
        logic          em2reg;
        logic          ewmem;
        logic          ejal;
        logic          ealuimm;
        logic          eshift;
        logic [4:0]    ealuc;
        logic [1:0]    estore_depen;
        logic [4:0]    ern;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [DW-1:0] eimm;
        logic [DW-1:0] epc4;
        logic          ex_is_uncond;
        logic          ex_is_cond;
        logic [CW-1:0] bubble_cnt;
        logic [CW-1:0] flush_cnt;
    } out_t;

    typedef struct {
        out_t  v;
        string nm;
    } exp_t;

    logic          clock;
    logic          resetn;
    logic          load_depen, flush;
    logic          dwreg, dm2reg, dwmem, djal, dj, dbeq, dbne;
    logic [4:0]    daluc;
    logic          daluimm, dshift;
    logic [1:0]    dstore_depen;
    logic [4:0]    drn;
    logic [DW-1:0] da, db, dimm, dpc4;

    logic          ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
    logic [4:0]    ealuc;
    logic [1:0]    estore_depen;
    logic [4:0]    ern;
    logic [DW-1:0] ea, eb, eimm, epc4;
    logic          ex_is_uncond, ex_is_cond;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    pipe_idex_reg #(.DW(DW), .CW(CW)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .load_depen   (load_depen),
        .flush        (flush),
        .dwreg        (dwreg),
        .dm2reg       (dm2reg),
        .dwmem        (dwmem),
        .djal         (djal),
        .dj           (dj),
        .dbeq         (dbeq),
        .dbne         (dbne),
        .daluc        (daluc),
        .daluimm      (daluimm),
        .dshift       (dshift),
        .dstore_depen (dstore_depen),
        .drn          (drn),
        .da           (da),
        .db           (db),
        .dimm         (dimm),
        .dpc4         (dpc4),
        .ewreg        (ewreg),
        .em2reg       (em2reg),
        .ewmem        (ewmem),
        .ejal         (ejal),
        .ealuimm      (ealuimm),
        .eshift       (eshift),
        .ealuc        (ealuc),
        .estore_depen (estore_depen),
        .ern          (ern),
        .ea           (ea),
        .eb           (eb),
        .eimm         (eimm),
        .epc4         (epc4),
        .ex_is_uncond (ex_is_uncond),
        .ex_is_cond   (ex_is_cond),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic out_t sample();
        out_t o;
        o.ewreg        = ewreg;
        o.em2reg       = em2reg;
        o.ewmem        = ewmem;
        o.ejal         = ejal;
        o.ealuimm      = ealuimm;
        o.eshift       = eshift;
        o.ealuc        = ealuc;
        o.estore_depen = estore_depen;
        o.ern          = ern;
        o.ea           = ea;
        o.eb           = eb;
        o.eimm         = eimm;
        o.epc4         = epc4;
        o.ex_is_uncond = ex_is_uncond;
        o.ex_is_cond   = ex_is_cond;
        o.bubble_cnt   = bubble_cnt;
        o.flush_cnt    = flush_cnt;
        return o;
    endfunction

    // Expected EX image for one ID vector; counters are supplied by the caller.
    function automatic out_t model(input in_t v, input logic [CW-1:0] bc,
                                   input logic [CW-1:0] fc);
        out_t o;
        logic bub;
        bub            = v.flush | v.load_depen;
        o              = '0;
        o.ewreg        = v.dwreg  & ~bub;
        o.em2reg       = v.dm2reg & ~bub;
        o.ewmem        = v.dwmem  & ~bub;
        o.ejal         = v.djal   & ~bub;
        o.ex_is_uncond = (v.dj | v.djal) & ~bub;
        o.ex_is_cond   = (v.dbeq | v.dbne) & ~bub;
        o.estore_depen = bub ? 2'b00 : v.dstore_depen;
        o.ern          = bub ? 5'd0  : v.drn;
        o.ealuc        = v.daluc;
        o.ealuimm      = v.daluimm;
        o.eshift       = v.dshift;
        o.ea           = v.da;
        o.eb           = v.db;
        o.eimm         = v.dimm;
        o.epc4         = v.dpc4;
        o.bubble_cnt   = bc;
        o.flush_cnt    = fc;
        return o;
    endfunction

    task automatic apply(input in_t v);
        flush        = v.flush;
        load_depen   = v.load_depen;
        dwreg        = v.dwreg;
        dm2reg       = v.dm2reg;
        dwmem        = v.dwmem;
        djal         = v.djal;
        dj           = v.dj;
        dbeq         = v.dbeq;
        dbne         = v.dbne;
        daluc        = v.daluc;
        daluimm      = v.daluimm;
        dshift       = v.dshift;
        dstore_depen = v.dstore_depen;
        drn          = v.drn;
        da           = v.da;
        db           = v.db;
        dimm         = v.dimm;
        dpc4         = v.dpc4;
    endtask

    // Immediate (non-edge) comparison, used for asynchronous reset checks.
    task automatic check_now(input string nm, input out_t e);
        out_t a;
        a = sample();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endtask

    // One cycle of stimulus: apply after the falling edge, queue the result.
    task automatic drive(input in_t v, input logic [CW-1:0] bc,
                         input logic [CW-1:0] fc, input string nm);
        exp_t e;
        @(negedge clock);
        #1;
        resetn = 1'b1;
        apply(v);
        e.v  = model(v, bc, fc);
        e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: one queued expectation per clock edge.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            out_t a;
            e = sb_q.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.nm, a, e.v);
            end
        end
    end

    function automatic in_t nz_vec();
        in_t v;
        v              = '0;
        v.dwreg        = 1'b1;
        v.dm2reg       = 1'b1;
        v.dwmem        = 1'b1;
        v.djal         = 1'b1;
        v.dj           = 1'b1;
        v.dbeq         = 1'b1;
        v.dbne         = 1'b1;
        v.daluc        = 5'b10101;
        v.daluimm      = 1'b1;
        v.dshift       = 1'b1;
        v.dstore_depen = 2'b11;
        v.drn          = 5'd31;
        v.da           = 32'hA5A5_0001;
        v.db           = 32'h5A5A_0002;
        v.dimm         = 32'hFFFF_FF80;
        v.dpc4         = 32'h0000_0404;
        return v;
    endfunction

    initial begin
        in_t  v;
        exp_t e;
        logic [CW-1:0] bc;
        logic [CW-1:0] fc;
        int   guard;

        // power-on reset with every ID input nonzero
        resetn = 1'b0;
        apply(nz_vec());
        #1;
        check_now("por_async", '0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check_now("por_edges_ignored", '0);

        // full pass-through of a busy vector
        drive(nz_vec(), 4'd0, 4'd0, "nz_pass");

        // asynchronous reset mid-stream, between edges
        @(negedge clock);
        #1;
        apply(nz_vec());
        resetn = 1'b0;
        #1;
        check_now("mid_reset_async", '0);
        e.v  = '0;
        e.nm = "mid_reset_edge";
        sb_q.push_back(e);

        // release: first edge captures normally
        v = '0; v.dwreg = 1'b1; v.drn = 5'd3; v.da = 32'h1234;
        drive(v, 4'd0, 4'd0, "post_reset");

        v = '0; v.dwmem = 1'b1; v.dstore_depen = 2'b01; v.db = 32'hDEAD; v.daluc = 5'b00010;
        drive(v, 4'd0, 4'd0, "store_pass");

        // load-use stall then release
        v = '0; v.dwreg = 1'b1; v.dm2reg = 1'b1; v.drn = 5'd7; v.load_depen = 1'b1;
        drive(v, 4'd1, 4'd0, "load_bubble");
        v.load_depen = 1'b0;
        drive(v, 4'd1, 4'd0, "load_resume");

        // branch flags and flush
        v = '0; v.dbeq = 1'b1;
        drive(v, 4'd1, 4'd0, "beq_cond");
        v = '0; v.djal = 1'b1; v.dwreg = 1'b1; v.drn = 5'd31; v.flush = 1'b1;
        drive(v, 4'd1, 4'd1, "jal_flushed");
        v.flush = 1'b0;
        drive(v, 4'd1, 4'd1, "jal_uncond");
        v = '0; v.dj = 1'b1;
        drive(v, 4'd1, 4'd1, "j_uncond");
        v = '0; v.dbne = 1'b1; v.dj = 1'b1; v.load_depen = 1'b1;
        drive(v, 4'd2, 4'd1, "flags_stalled");

        // simultaneous hazards: one bubble, flush gets the count
        v = nz_vec(); v.load_depen = 1'b1; v.flush = 1'b1;
        drive(v, 4'd2, 4'd2, "both_hazards");

        // $0 destination passes through untouched
        v = '0; v.dwreg = 1'b1; v.drn = 5'd0; v.da = 32'hCAFE_F00D;
        drive(v, 4'd2, 4'd2, "rn_zero_pass");

        // bubble counter saturation
        for (int k = 0; k < 20; k++) begin
            v = '0; v.load_depen = 1'b1; v.dpc4 = 32'(k * 4);
            bc = (k + 3 > 15) ? 4'd15 : 4'(k + 3);
            drive(v, bc, 4'd2, "bubble_sat");
        end

        // flush counter saturation
        for (int k = 0; k < 15; k++) begin
            v = '0; v.flush = 1'b1; v.dj = 1'b1;
            fc = (k + 3 > 15) ? 4'd15 : 4'(k + 3);
            drive(v, 4'd15, fc, "flush_sat");
        end

        // drain the scoreboard, bounded
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
